// File: rtl/axa_mult_arbiter_if.sv
// Signal bundle between axa_mult_arbiter, its client engines and the shared 2x2 multiplier.
// The master view is the arbiter itself; the slave view is everything around it.
interface axa_mult_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
);
   logic [NUM_REQ-1:0]     input_Req;
   logic [NUM_REQ*128-1:0] input_Req_A;
   logic [NUM_REQ*128-1:0] input_Req_B;
   logic [NUM_REQ-1:0]     input_Done_Ack;
   logic [NUM_REQ-1:0]     output_Grant;
   logic [NUM_REQ-1:0]     output_Done;
   logic [31:0]            output_C11, output_C12, output_C21, output_C22;
   logic                   output_Mult_Start;
   logic                   output_Mult_Stable;
   logic [31:0]            output_Mult_A11, output_Mult_A12, output_Mult_A21, output_Mult_A22;
   logic [31:0]            output_Mult_B11, output_Mult_B12, output_Mult_B21, output_Mult_B22;
   logic                   input_Mult_AB_Ack;
   logic                   input_Mult_Stable;
   logic [31:0]            input_Mult_C11, input_Mult_C12, input_Mult_C21, input_Mult_C22;
   logic                   output_Mult_C_Ack;
   logic                   output_Busy;
   logic [CNT_W-1:0]       output_Op_Count;

   modport master (
      input  input_Req, input_Req_A, input_Req_B, input_Done_Ack,
      input  input_Mult_AB_Ack, input_Mult_Stable,
      input  input_Mult_C11, input_Mult_C12, input_Mult_C21, input_Mult_C22,
      output output_Grant, output_Done,
      output output_C11, output_C12, output_C21, output_C22,
      output output_Mult_Start, output_Mult_Stable, output_Mult_C_Ack,
      output output_Mult_A11, output_Mult_A12, output_Mult_A21, output_Mult_A22,
      output output_Mult_B11, output_Mult_B12, output_Mult_B21, output_Mult_B22,
      output output_Busy, output_Op_Count
   );

   modport slave (
      output input_Req, input_Req_A, input_Req_B, input_Done_Ack,
      output input_Mult_AB_Ack, input_Mult_Stable,
      output input_Mult_C11, input_Mult_C12, input_Mult_C21, input_Mult_C22,
      input  output_Grant, output_Done,
      input  output_C11, output_C12, output_C21, output_C22,
      input  output_Mult_Start, output_Mult_Stable, output_Mult_C_Ack,
      input  output_Mult_A11, output_Mult_A12, output_Mult_A21, output_Mult_A22,
      input  output_Mult_B11, output_Mult_B12, output_Mult_B21, output_Mult_B22,
      input  output_Busy, output_Op_Count
   );
endinterface

// File: rtl/axa_mult_arbiter.sv
// Round-robin scheduler sharing one 2x2 single-precision matrix multiplier among NUM_REQ clients.
// Latches the winner's operands, runs the Start/Stable/C_Ack handshake and returns C via Done/Ack.
module axa_mult_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input logic                input_Clk,
   input logic                input_Reset_n,
   axa_mult_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RELEASE,
      S_DELIVER
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;
   logic [127:0]       a_q;
   logic [127:0]       b_q;
   logic [127:0]       c_q;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] done;
   logic               start;
   logic               stable;
   logic               c_ack;
   logic               busy;
   logic [CNT_W-1:0]   op_count;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      return NUM_REQ'(1) << i;
   endfunction

   // Scan from farthest to nearest distance above the pointer so the nearest request wins.
   // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] j_idx;
      win_valid = 1'b0;
      win_idx   = '0;
      j         = 0;
      j_idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         j_idx = IDX_W'(j);
         if (bus.input_Req[j_idx]) begin
            win_valid = 1'b1;
            win_idx   = j_idx;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
   always_ff @(posedge input_Clk or negedge input_Reset_n) begin
      if (!input_Reset_n) begin
         state    <= S_IDLE;
         ptr      <= '0;
         idx      <= '0;
         // NOTE: operand and result registers are reset too, because they drive outputs that must read zero.
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         grant    <= '0;
         done     <= '0;
         start    <= 1'b0;
         stable   <= 1'b0;
         c_ack    <= 1'b0;
         busy     <= 1'b0;
         op_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_valid) begin
                  idx    <= win_idx;
                  a_q    <= bus.input_Req_A[128*win_idx +: 128];
                  b_q    <= bus.input_Req_B[128*win_idx +: 128];
                  grant  <= onehot(win_idx);
                  busy   <= 1'b1;
                  start  <= 1'b1;
                  stable <= 1'b1;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.input_Mult_AB_Ack) begin
                  start <= 1'b0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.input_Mult_Stable) begin
                  c_q    <= {bus.input_Mult_C11, bus.input_Mult_C12,
                             bus.input_Mult_C21, bus.input_Mult_C22};
                  stable <= 1'b0;
                  c_ack  <= 1'b1;
                  state  <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!bus.input_Mult_Stable) begin
                  c_ack <= 1'b0;
                  done  <= onehot(idx);
                  state <= S_DELIVER;
               end
            end
            S_DELIVER: begin
               // Only the granted requester's ack can close the delivery.
               if (bus.input_Done_Ack[idx]) begin
                  done     <= '0;
                  grant    <= '0;
                  busy     <= 1'b0;
                  op_count <= op_count + CNT_W'(1);
                  ptr      <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.output_Grant       = grant;
   assign bus.output_Done        = done;
   assign bus.output_Busy        = busy;
   assign bus.output_Op_Count    = op_count;
   assign bus.output_Mult_Start  = start;
   assign bus.output_Mult_Stable = stable;
   assign bus.output_Mult_C_Ack  = c_ack;

   assign bus.output_C11 = c_q[127:96];
   assign bus.output_C12 = c_q[95:64];
   assign bus.output_C21 = c_q[63:32];
   assign bus.output_C22 = c_q[31:0];

   assign bus.output_Mult_A11 = a_q[127:96];
   assign bus.output_Mult_A12 = a_q[95:64];
   assign bus.output_Mult_A21 = a_q[63:32];
   assign bus.output_Mult_A22 = a_q[31:0];
   assign bus.output_Mult_B11 = b_q[127:96];
   assign bus.output_Mult_B12 = b_q[95:64];
   assign bus.output_Mult_B21 = b_q[63:32];
   assign bus.output_Mult_B22 = b_q[31:0];
endmodule

// File: tb/tb_axa_mult_arbiter.sv
// Directed bench for axa_mult_arbiter: a behavioural 2x2 float multiplier, a vector table
// of single-request operations and hand-written sequences for arbitration and reset corners.
module tb_axa_mult_arbiter;
   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 16;

   typedef struct {
      int           idx;
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] c;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [CNT_W-1:0] exp_count = '0;

   int lat  = 2;
   int hold = 0;
   int m_phase = 0;
   int m_cnt   = 0;
   logic [31:0] m_a [4];
   logic [31:0] m_b [4];
   int viol_overlap = 0;
   int viol_early   = 0;

   vec_t vecs [6];

   axa_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

   axa_mult_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .input_Clk     (clk),
      .input_Reset_n (rst_n),
      .bus           (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [NUM_REQ-1:0] oh(input int i);
      return NUM_REQ'(1) << i;
   endfunction

   function automatic real sp2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
   endfunction

   function automatic logic [127:0] c_out();
      return {bus.output_C11, bus.output_C12, bus.output_C21, bus.output_C22};
   endfunction

   function automatic logic [127:0] mult_a();
      return {bus.output_Mult_A11, bus.output_Mult_A12, bus.output_Mult_A21, bus.output_Mult_A22};
   endfunction

   function automatic logic [127:0] mult_b();
      return {bus.output_Mult_B11, bus.output_Mult_B12, bus.output_Mult_B21, bus.output_Mult_B22};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_grant"},  bus.output_Grant, '0);
      check({tag, "_done"},   bus.output_Done, '0);
      check({tag, "_busy"},   bus.output_Busy, '0);
      check({tag, "_start"},  bus.output_Mult_Start, '0);
      check({tag, "_stable"}, bus.output_Mult_Stable, '0);
      check({tag, "_c_ack"},  bus.output_Mult_C_Ack, '0);
      check({tag, "_count"},  bus.output_Op_Count, '0);
      check({tag, "_c"},      c_out(), '0);
      check({tag, "_mult_a"}, mult_a(), '0);
      check({tag, "_mult_b"}, mult_b(), '0);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (bus.output_Done == '0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.output_Done == '0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no Done within %0d cycles, expected Done", name, n);
      end
   endtask

   task automatic ack_done(input int i);
      bus.input_Done_Ack = oh(i);
      @(negedge clk);
      bus.input_Done_Ack = '0;
      exp_count = exp_count + CNT_W'(1);
      check("done_cleared", bus.output_Done, '0);
      check("grant_cleared", bus.output_Grant, '0);
      check("op_count", bus.output_Op_Count, exp_count);
   endtask

   task automatic do_reset(input logic [NUM_REQ-1:0] req);
      @(negedge clk);
      #2 rst_n = 1'b0;
      bus.input_Req      = req;
      bus.input_Done_Ack = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      exp_count = '0;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      bus.input_Req_A[128*v.idx +: 128] = v.a;
      bus.input_Req_B[128*v.idx +: 128] = v.b;
      bus.input_Req = oh(v.idx);
      @(negedge clk);
      check("grant", bus.output_Grant, oh(v.idx));
      check("start", bus.output_Mult_Start, 1'b1);
      check("busy", bus.output_Busy, 1'b1);
      check("mult_a", mult_a(), v.a);
      check("mult_b", mult_b(), v.b);
      bus.input_Req = '0;
      wait_done("vec");
      check("done", bus.output_Done, oh(v.idx));
      check("result", c_out(), v.c);
      ack_done(v.idx);
   endtask

   // Behavioural multiplier: acks after two cycles of Start, result after lat cycles,
   // drops Stable hold cycles after it first sees C_Ack.
   initial begin
      bus.input_Mult_AB_Ack = 1'b0;
      bus.input_Mult_Stable = 1'b0;
      bus.input_Mult_C11 = '0; bus.input_Mult_C12 = '0;
      bus.input_Mult_C21 = '0; bus.input_Mult_C22 = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            bus.input_Mult_AB_Ack = 1'b0;
            bus.input_Mult_Stable = 1'b0;
         end else begin
            case (m_phase)
               0: if (bus.output_Mult_Start) begin
                  m_cnt++;
                  if (m_cnt >= 2) begin
                     bus.input_Mult_AB_Ack = 1'b1;
                     m_a[0] = bus.output_Mult_A11; m_a[1] = bus.output_Mult_A12;
                     m_a[2] = bus.output_Mult_A21; m_a[3] = bus.output_Mult_A22;
                     m_b[0] = bus.output_Mult_B11; m_b[1] = bus.output_Mult_B12;
                     m_b[2] = bus.output_Mult_B21; m_b[3] = bus.output_Mult_B22;
                     m_phase = 1;
                     m_cnt   = 0;
                  end
               end
               1: begin
                  bus.input_Mult_AB_Ack = 1'b0;
                  m_cnt++;
                  if (m_cnt >= lat) begin
                     bus.input_Mult_C11 = r2sp(sp2r(m_a[0])*sp2r(m_b[0]) + sp2r(m_a[1])*sp2r(m_b[2]));
                     bus.input_Mult_C12 = r2sp(sp2r(m_a[0])*sp2r(m_b[1]) + sp2r(m_a[1])*sp2r(m_b[3]));
                     bus.input_Mult_C21 = r2sp(sp2r(m_a[2])*sp2r(m_b[0]) + sp2r(m_a[3])*sp2r(m_b[2]));
                     bus.input_Mult_C22 = r2sp(sp2r(m_a[2])*sp2r(m_b[1]) + sp2r(m_a[3])*sp2r(m_b[3]));
                     bus.input_Mult_Stable = 1'b1;
                     m_phase = 2;
                     m_cnt   = 0;
                  end
               end
               default: if (bus.output_Mult_C_Ack) begin
                  if (m_cnt >= hold) begin
                     bus.input_Mult_Stable = 1'b0;
                     m_phase = 0;
                     m_cnt   = 0;
                  end else begin
                     m_cnt++;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bus.output_Mult_Start && bus.output_Mult_C_Ack) viol_overlap++;
         if ((|bus.output_Done) && bus.input_Mult_Stable) viol_early++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test after 100000 ns, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.input_Req      = '0;
      bus.input_Req_A    = '0;
      bus.input_Req_B    = '0;
      bus.input_Done_Ack = '0;

      //          idx  A {11,12,21,22}                                         B                                                      C = A x B
      vecs[0] = '{0, {32'h3F800000, 32'h0,        32'h0,        32'h3F800000}, {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000}, {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000}};
      vecs[1] = '{1, {32'h40000000, 32'h0,        32'h0,        32'h40000000}, {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, {32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000}};
      vecs[2] = '{2, {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, {32'h3F800000, 32'h0,        32'h0,        32'h3F800000}, {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}};
      vecs[3] = '{3, {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, {32'h40800000, 32'h40C00000, 32'h40800000, 32'h40C00000}};
      vecs[4] = '{2, {32'h0,        32'h3F800000, 32'h3F800000, 32'h0},        {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000}, {32'h40800000, 32'h40A00000, 32'h40000000, 32'h40400000}};
      vecs[5] = '{1, {32'hBF800000, 32'h0,        32'h0,        32'hBF800000}, {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000}, {32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000}};

      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 check_zero("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Operand isolation and request withdrawal while in flight.
      @(negedge clk);
      bus.input_Req_A[127:0] = vecs[0].a;
      bus.input_Req_B[127:0] = vecs[0].b;
      bus.input_Req = 4'b0001;
      @(negedge clk);
      check("iso_grant", bus.output_Grant, 4'b0001);
      @(negedge clk);
      bus.input_Req_B[127:0] = '0;
      bus.input_Req = '0;
      wait_done("iso");
      check("iso_done", bus.output_Done, 4'b0001);
      check("iso_result", c_out(), vecs[0].c);
      ack_done(0);

      // Multiplier holding Stable three cycles past C_Ack.
      hold = 3;
      run_vec(vecs[4]);
      hold = 0;
      check("start_cack_overlap", viol_overlap, 0);
      check("done_before_stable_fall", viol_early, 0);

      // All four requesting from reset: 0,1,2,3,0 with a new grant two edges after each ack.
      do_reset(4'b1111);
      check("rr_first_grant", bus.output_Grant, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         wait_done("rr");
         check("rr_done", bus.output_Done, oh(k % 4));
         ack_done(k % 4);
         @(negedge clk);
         check("rr_next_grant", bus.output_Grant, oh((k + 1) % 4));
         check("rr_next_start", bus.output_Mult_Start, 1'b1);
      end

      // Fairness between requesters 0 and 2; a stray ack from a non-granted requester is ignored.
      do_reset(4'b0101);
      check("fair_first_grant", bus.output_Grant, 4'b0001);
      for (int k = 0; k < 4; k++) begin
         wait_done("fair");
         check("fair_done", bus.output_Done, oh((k % 2) * 2));
         if (k == 0) begin
            bus.input_Done_Ack = 4'b0110;
            @(negedge clk);
            bus.input_Done_Ack = '0;
            check("stray_ack_ignored", bus.output_Done, 4'b0001);
         end
         ack_done((k % 2) * 2);
         if (k < 3) begin
            @(negedge clk);
            check("fair_next_grant", bus.output_Grant, oh(((k + 1) % 2) * 2));
         end
      end

      // Asynchronous reset while waiting for the result, then the pointer restarts at 0.
      do_reset('0);
      run_vec(vecs[2]);
      lat = 20;
      @(negedge clk);
      bus.input_Req = 4'b1000;
      begin
         int n;
         n = 0;
         while (!(bus.output_Grant == 4'b1000 && !bus.output_Mult_Start && bus.output_Mult_Stable) && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("reach_wait", {bus.output_Grant, bus.output_Mult_Start, bus.output_Mult_Stable}, {4'b1000, 1'b0, 1'b1});
      end
      #2 rst_n = 1'b0;
      #1 check_zero("async");
      @(negedge clk);
      lat = 2;
      bus.input_Req_A[127:0] = vecs[0].a;
      bus.input_Req_B[127:0] = vecs[0].b;
      bus.input_Req = 4'b1001;
      #2 rst_n = 1'b1;
      exp_count = '0;
      @(negedge clk);
      check("post_reset_grant", bus.output_Grant, 4'b0001);
      bus.input_Req = 4'b1000;
      wait_done("post_reset");
      check("post_reset_result", c_out(), vecs[0].c);
      ack_done(0);
      @(negedge clk);
      check("post_reset_next_grant", bus.output_Grant, 4'b1000);
      bus.input_Req = '0;
      wait_done("post_reset_3");
      check("post_reset_3_result", c_out(), vecs[3].c);
      ack_done(3);

      // Counter wrap after a forced preload.
      @(negedge clk);
      force dut.op_count = 16'hFFFF;
      #1 release dut.op_count;
      #1 check("preload", bus.output_Op_Count, 16'hFFFF);
      exp_count = 16'hFFFF;
      run_vec(vecs[1]);
      check("wrap_to_zero", bus.output_Op_Count, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
